// File: rtl/dmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_pkg
//  Brief    : Shared types and constants for the DMAC channel arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package dmac_pkg;

  // Arbiter / bus-ownership sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_BUS = 3'd1,
    ACTIVE  = 3'd2,
    PAUSE   = 3'd3,
    DONE    = 3'd4
  } arb_state_e;

  // Encodings of the RR_MODE parameter.
  localparam int c_rr_mode_fixed = 0;
  localparam int c_rr_mode_rr    = 1;

endpackage : dmac_pkg
`default_nettype wire

// File: rtl/dmac_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_rr_picker
//  Brief    : Combinational priority search over pending channel requests.
//             mode=1 searches upward from rr_ptr with wrap-around,
//             mode=0 picks the lowest set index.
//  Revision : 1.0 - initial release
// ============================================================================
module dmac_rr_picker #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] rr_ptr,
  input  logic                      mode,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      valid
);

  localparam int            IW    = $clog2(NUM_CH);
  // One extra bit so base + offset never overflows before the wrap.
  localparam logic [IW:0]   c_num = (IW+1)'(NUM_CH);

  logic [IW-1:0] w_base;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    w_base    = mode ? rr_ptr : '0;
    w_sum     = '0;
    w_idx     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_sum = {1'b0, w_base} + (IW+1)'(i);
      if (w_sum >= c_num) begin
        w_sum = w_sum - c_num;
      end
      w_idx = w_sum[IW-1:0];
      if (pending[w_idx]) begin
        grant_idx = w_idx;
        valid     = 1'b1;
      end
    end
  end

endmodule : dmac_rr_picker
`default_nettype wire

// File: rtl/dmac_ch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_ch_arbiter
//  Brief    : N-channel DMAC request arbiter and AHB bus-ownership sequencer.
//             Selects a channel, requests the bus, starts/stalls the transfer
//             engine and acknowledges/flags the channel on completion.
//  Revision : 1.0 - initial release
// ============================================================================
module dmac_ch_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         DmacReq,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      Bus_Grant,
  input  logic                      ch_done,
  input  logic [NUM_CH-1:0]         irq_clr,
  output logic                      Bus_Req,
  output logic [$clog2(NUM_CH)-1:0] ch_id,
  output logic                      ch_start,
  output logic                      ch_hold,
  output logic [NUM_CH-1:0]         ReqAck,
  output logic [NUM_CH-1:0]         irq_status,
  output logic                      Interrupt
);

  localparam int            IW     = $clog2(NUM_CH);
  localparam logic [IW-1:0] c_last = IW'(NUM_CH - 1);
  localparam logic          c_mode = (RR_MODE == c_rr_mode_rr) ? 1'b1 : 1'b0;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IW-1:0]     r_ch_id;
  logic [IW-1:0]     r_rr_ptr;
  logic              r_ch_start;
  logic [NUM_CH-1:0] r_irq;
  logic [NUM_CH-1:0] w_pending;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic [NUM_CH-1:0] w_ack;

  assign w_pending = DmacReq & ch_en;

  dmac_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .pending   (w_pending),
    .rr_ptr    (r_rr_ptr),
    .mode      (c_mode),
    .grant_idx (w_pick_idx),
    .valid     (w_pick_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; completion beats a simultaneous grant loss.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = REQ_BUS;
      REQ_BUS: begin
        if (!ch_en[r_ch_id])  w_state_nxt = IDLE;
        else if (Bus_Grant)   w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (ch_done)          w_state_nxt = DONE;
        else if (!Bus_Grant)  w_state_nxt = PAUSE;
      end
      PAUSE:   if (Bus_Grant) w_state_nxt = ACTIVE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded directly from the state register.
  always_comb begin
    w_ack = '0;
    if (r_state == DONE) begin
      w_ack[r_ch_id] = 1'b1;
    end
  end

  assign Bus_Req    = (r_state == REQ_BUS) || (r_state == ACTIVE) || (r_state == PAUSE);
  assign ch_hold    = (r_state == PAUSE);
  assign ReqAck     = w_ack;
  assign ch_id      = r_ch_id;
  assign ch_start   = r_ch_start;
  assign irq_status = r_irq;
  assign Interrupt  = |r_irq;

  // Channel latch, start pulse, rotation pointer and sticky completion flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch_id    <= '0;
      r_rr_ptr   <= '0;
      r_ch_start <= 1'b0;
      r_irq      <= '0;
    end else begin
      if ((r_state == IDLE) && w_pick_valid) begin
        r_ch_id <= w_pick_idx;
      end
      // Only the REQ_BUS->ACTIVE edge starts the engine; PAUSE->ACTIVE does not.
      r_ch_start <= (r_state == REQ_BUS) && (w_state_nxt == ACTIVE);
      if (r_state == DONE) begin
        r_rr_ptr <= (r_ch_id == c_last) ? '0 : r_ch_id + IW'(1);
      end
      // A completion set overrides a clear of the same bit.
      r_irq <= (r_irq & ~irq_clr) | w_ack;
    end
  end

endmodule : dmac_ch_arbiter
`default_nettype wire

// File: tb/tb_dmac_ch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmac_ch_arbiter
//  Brief    : Self-checking bench for dmac_ch_arbiter (round-robin instance
//             plus a fixed-priority instance sharing the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmac_ch_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] DmacReq = '0;
  logic [N-1:0] ch_en = '0;
  logic         Bus_Grant = 1'b0;
  logic         ch_done = 1'b0;
  logic [N-1:0] irq_clr = '0;

  logic         Bus_Req, ch_start, ch_hold, Interrupt;
  logic [1:0]   ch_id;
  logic [N-1:0] ReqAck, irq_status;

  logic         f_bus_req, f_ch_start, f_ch_hold, f_interrupt;
  logic [1:0]   f_ch_id;
  logic [N-1:0] f_req_ack, f_irq_status;

  int           n_total = 0;
  int           n_bad   = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_irq   = '0;
  logic [N-1:0] m_irq_f = '0;

  always #5 clk = ~clk;

  dmac_ch_arbiter #(.NUM_CH(N), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .ch_en(ch_en), .Bus_Grant(Bus_Grant),
    .ch_done(ch_done), .irq_clr(irq_clr), .Bus_Req(Bus_Req), .ch_id(ch_id),
    .ch_start(ch_start), .ch_hold(ch_hold), .ReqAck(ReqAck),
    .irq_status(irq_status), .Interrupt(Interrupt)
  );

  dmac_ch_arbiter #(.NUM_CH(N), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .ch_en(ch_en), .Bus_Grant(Bus_Grant),
    .ch_done(ch_done), .irq_clr(irq_clr), .Bus_Req(f_bus_req), .ch_id(f_ch_id),
    .ch_start(f_ch_start), .ch_hold(f_ch_hold), .ReqAck(f_req_ack),
    .irq_status(f_irq_status), .Interrupt(f_interrupt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requesting channel at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic idle_clear(input logic [N-1:0] clr);
    DmacReq = '0;
    irq_clr = clr;
    tick();
    irq_clr = '0;
    m_irq   = m_irq & ~clr;
    m_irq_f = m_irq_f & ~clr;
    chk("irq_clr", irq_status, m_irq);
    chk("intr_clr", Interrupt, |m_irq);
    chk("fix_irq_clr", f_irq_status, m_irq_f);
  endtask

  // One full transfer from IDLE back to IDLE, checked cycle by cycle.
  task automatic run_xfer(input logic [N-1:0] req, input logic [N-1:0] en,
                          input int gnt_dly, input int pause_len, input int done_dly,
                          input logic [N-1:0] clr, input bit drop_at_done);
    logic [N-1:0] pend, oh, oh_f;
    int w, wf;
    pend = req & en;
    w    = pick(pend, m_ptr);
    wf   = pick(pend, 0);
    oh   = N'(1) << w;
    oh_f = N'(1) << wf;
    DmacReq = req;
    ch_en   = en;
    tick();
    chk("busreq_rise", Bus_Req, 1);
    chk("ch_id", ch_id, w);
    chk("fix_busreq_rise", f_bus_req, 1);
    chk("fix_ch_id", f_ch_id, wf);
    chk("no_early_start", ch_start, 0);
    repeat (gnt_dly) begin
      tick();
      chk("busreq_wait", Bus_Req, 1);
      chk("start_wait", ch_start, 0);
    end
    Bus_Grant = 1'b1;
    tick();
    chk("start", ch_start, 1);
    chk("fix_start", f_ch_start, 1);
    chk("hold_active", ch_hold, 0);
    if (pause_len > 0) begin
      Bus_Grant = 1'b0;
      for (int c = 0; c < pause_len; c++) begin
        tick();
        chk("hold", ch_hold, 1);
        chk("fix_hold", f_ch_hold, 1);
        chk("busreq_pause", Bus_Req, 1);
        chk("start_pause", ch_start, 0);
        // A completion pulse while paused must be ignored.
        ch_done = (c == 0) && (pause_len > 1);
      end
      ch_done   = 1'b0;
      Bus_Grant = 1'b1;
      tick();
      chk("hold_release", ch_hold, 0);
      chk("no_restart", ch_start, 0);
    end
    repeat (done_dly) begin
      tick();
      chk("start_pulse_end", ch_start, 0);
      chk("busreq_active", Bus_Req, 1);
    end
    ch_done = 1'b1;
    if (drop_at_done) Bus_Grant = 1'b0;
    tick();
    ch_done = 1'b0;
    chk("reqack", ReqAck, oh);
    chk("fix_reqack", f_req_ack, oh_f);
    chk("busreq_done", Bus_Req, 0);
    chk("hold_done", ch_hold, 0);
    chk("irq_before", irq_status, m_irq);
    irq_clr   = clr;
    DmacReq   = '0;
    Bus_Grant = 1'b0;
    tick();
    irq_clr = '0;
    m_irq   = (m_irq & ~clr) | oh;
    m_irq_f = (m_irq_f & ~clr) | oh_f;
    m_ptr   = (w + 1) % N;
    chk("reqack_end", ReqAck, 0);
    chk("irq", irq_status, m_irq);
    chk("intr", Interrupt, |m_irq);
    chk("fix_irq", f_irq_status, m_irq_f);
    chk("fix_intr", f_interrupt, |m_irq_f);
    chk("idle_gap", Bus_Req, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busreq"}, Bus_Req, 0);
    chk({tag, "_ch_id"}, ch_id, 0);
    chk({tag, "_start"}, ch_start, 0);
    chk({tag, "_hold"}, ch_hold, 0);
    chk({tag, "_reqack"}, ReqAck, 0);
    chk({tag, "_irq"}, irq_status, 0);
    chk({tag, "_intr"}, Interrupt, 0);
  endtask

  initial begin
    logic [N-1:0] r_req, r_en;
    int p_len;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    tick();
    chk("idle_busreq", Bus_Req, 0);

    // Round-robin fairness with every channel requesting: 0,1,2,3,0 (fixed: all 0).
    for (int i = 0; i < 5; i++) begin
      run_xfer(4'b1111, 4'b1111, 0, 0, 2, 4'b0000, 1'b0);
    end

    // Single request on ch2, grant after 2 cycles, done 5 cycles later.
    run_xfer(4'b0100, 4'b0100, 2, 0, 5, 4'b0000, 1'b0);

    // Grant withdrawn for 3 cycles mid-transfer.
    run_xfer(4'b0010, 4'b1111, 1, 3, 2, 4'b0000, 1'b0);

    // Abort in REQ_BUS when the channel is disabled before grant.
    DmacReq = 4'b0010;
    ch_en   = 4'b0010;
    tick();
    chk("abort_busreq_rise", Bus_Req, 1);
    chk("abort_ch_id", ch_id, 1);
    ch_en = 4'b0000;
    tick();
    chk("abort_busreq", Bus_Req, 0);
    chk("abort_reqack", ReqAck, 0);
    tick();
    chk("abort_irq", irq_status, m_irq);
    chk("abort_idle", Bus_Req, 0);
    DmacReq = '0;
    ch_en   = 4'b1111;

    // Clear collides with a completion set; a different bit clears normally.
    idle_clear(4'b0110);
    run_xfer(4'b0001, 4'b1111, 0, 0, 1, 4'b1001, 1'b0);
    chk("irq_collision", irq_status, 4'b0001);

    // Grant loss in the same cycle as completion: completion wins.
    run_xfer(4'b0010, 4'b1111, 0, 0, 1, 4'b0000, 1'b1);

    // Asynchronous reset in the middle of an ACTIVE transfer on ch3.
    DmacReq = 4'b1000;
    tick();
    chk("pre_rst_id", ch_id, 3);
    Bus_Grant = 1'b1;
    tick();
    chk("pre_rst_start", ch_start, 1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    DmacReq   = '0;
    Bus_Grant = 1'b0;
    #1 rst = 1'b1;
    m_ptr   = 0;
    m_irq   = '0;
    m_irq_f = '0;
    run_xfer(4'b1111, 4'b1111, 0, 0, 1, 4'b0000, 1'b0);

    // Randomized transfers.
    for (int it = 0; it < 40; it++) begin
      r_req = N'($urandom_range(1, 15));
      r_en  = N'($urandom_range(0, 15));
      if ((r_req & r_en) == '0) r_en = r_en | r_req;
      p_len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_xfer(r_req, r_en, int'($urandom_range(0, 3)), p_len, int'($urandom_range(0, 4)),
               N'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_clear(N'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_dmac_ch_arbiter
`default_nettype wire
